// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the BCD <-> binary conversion blocks.
//
// Contents:
//   state_e        : converter FSM encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   BCD_DIGIT_MAX  : largest legal value of one BCD nibble
//   NIBBLE_ADJ_THR : a nibble at or above this value is corrected by -3
//   NIBBLE_ADJ_SUB : correction applied to such a nibble
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [3:0] NIBBLE_ADJ_THR = 4'd8;
  localparam logic [3:0] NIBBLE_ADJ_SUB = 4'd3;

endpackage

// File: rtl/bcd_to_bin_seq_nibble_adj.sv
// Reverse double-dabble nibble correction.
//
// After a right shift, a BCD nibble that received a '1' from the digit above
// holds (value + 8). The tens weight crossing the digit boundary is
// 10/2 = 5, not 8, so 3 is removed to restore a proper BCD digit.
//
// Ports:
//   in_i  [3:0] : nibble after the shift
//   out_o [3:0] : corrected nibble (in_i - 3 when in_i >= 8, else in_i)
module bcd_nibble_adj
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= NIBBLE_ADJ_THR) ? (in_i - NIBBLE_ADJ_SUB) : in_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one result bit
// per clock. Shared between the alarm and clock-setting paths through a
// start/busy/done handshake.
//
// Handshake: a request is accepted on a rising edge where the FSM is idle and
// start=1; bcd_in is sampled on that edge only. busy is high from the cycle
// after acceptance up to and including the done cycle. done is a one-cycle
// pulse; bin_out/err are valid during it and hold until the next result.
// start while busy is dropped, not queued.
//
// Ports:
//   clk      : system clock
//   rst      : synchronous, active-high reset (aborts a conversion)
//   start    : conversion request, honoured only while idle
//   bcd_in   : packed BCD input, digit 0 in [3:0]
//   busy     : conversion in flight
//   done     : one-cycle result strobe
//   bin_out  : binary result (0 when err)
//   err      : some input nibble was above 9
//   state_o  : current FSM state, for observation
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic [1:0]            state_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CAT_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e             state_q,   state_d;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;
  logic [BIN_W-1:0]   bin_q,     bin_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q,     err_d;

  // Datapath for one iteration: shift {bcd, bin} right, then correct every
  // BCD nibble in parallel.
  logic [CAT_W-1:0]   cat_shift;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BIN_W-1:0]   bin_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic               in_bad;

  assign cat_shift = {bcd_q, bin_q} >> 1;
  assign bcd_shift = cat_shift[CAT_W-1:BIN_W];
  assign bin_shift = cat_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .in_i  (bcd_shift[4*g +: 4]),
      .out_o (bcd_adj[4*g +: 4])
    );
  end

  // Any non-decimal nibble in the request.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) in_bad = 1'b1;
    end
  end

  // Results are loaded on the edge entering DONE so that bin_out/err are
  // already valid while done is high.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = '0;
          if (in_bad) begin
            state_d   = ST_DONE;
            bin_out_d = '0;
            err_d     = 1'b1;
          end else begin
            state_d   = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          bin_out_d = bin_shift;
          err_d     = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign bin_out = bin_out_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: default 2-digit instance (a) and a 3-digit,
// 10-bit instance (b). Drivers push {err, bin} expectations into per-instance
// queues; monitors pop and compare on every done pulse.
module tb_bcd_to_bin_seq;
  import bcd_to_bin_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT a: DIGITS=2, BIN_W=7 ----------------
  logic        start_a;
  logic [7:0]  bcd_a;
  logic        busy_a, done_a, err_a;
  logic [6:0]  bin_a;
  logic [1:0]  st_a;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bcd_in(bcd_a),
    .busy(busy_a), .done(done_a), .bin_out(bin_a), .err(err_a),
    .state_o(st_a)
  );

  // ---------------- DUT b: DIGITS=3, BIN_W=10 ----------------
  logic        start_b;
  logic [11:0] bcd_b;
  logic        busy_b, done_b, err_b;
  logic [9:0]  bin_b;
  logic [1:0]  st_b;

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bcd_in(bcd_b),
    .busy(busy_b), .done(done_b), .bin_out(bin_b), .err(err_b),
    .state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_a_q[$];   // {err, bin[6:0]}
  logic [10:0] exp_b_q[$];   // {err, bin[9:0]}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && done_a === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        chk("a_unexpected_done", 1, 0);
      end else begin
        e = exp_a_q.pop_front();
        chk("a_bin_out", int'(bin_a), int'(e[6:0]));
        chk("a_err", int'(err_a), int'(e[7]));
      end
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst && done_b === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        chk("b_unexpected_done", 1, 0);
      end else begin
        e = exp_b_q.pop_front();
        chk("b_bin_out", int'(bin_b), int'(e[9:0]));
        chk("b_err", int'(err_b), int'(e[10]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one conversion, check done latency and busy length. If poke_k is
  // nonzero, a second start with poke_bcd is pulsed k cycles after acceptance.
  task automatic convert(input bit sel, input logic [11:0] bcd,
                         input int exp_bin, input bit exp_err,
                         input int exp_lat, input int poke_k,
                         input logic [11:0] poke_bcd);
    int busy_n;
    bit seen;
    @(negedge clk);
    if (sel) begin
      bcd_b = bcd; start_b = 1'b1;
      exp_b_q.push_back({exp_err, 10'(exp_bin)});
    end else begin
      bcd_a = bcd[7:0]; start_a = 1'b1;
      exp_a_q.push_back({exp_err, 7'(exp_bin)});
    end
    @(posedge clk);  // acceptance edge
    seen = 1'b0;
    busy_n = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin start_a = 1'b0; start_b = 1'b0; end
      if (poke_k != 0 && k == poke_k) begin
        if (sel) begin bcd_b = poke_bcd; start_b = 1'b1; end
        else begin bcd_a = poke_bcd[7:0]; start_a = 1'b1; end
      end
      if (poke_k != 0 && k == poke_k + 1) begin start_a = 1'b0; start_b = 1'b0; end
      if ((sel ? busy_b : busy_a) === 1'b1) busy_n++;
      if ((sel ? done_b : done_a) === 1'b1) begin
        seen = 1'b1;
        chk(sel ? "b_latency" : "a_latency", k, exp_lat);
        chk(sel ? "b_busy_cycles" : "a_busy_cycles", busy_n, exp_lat);
      end
    end
    if (!seen) chk(sel ? "b_done_timeout" : "a_done_timeout", 0, 1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Start 8'h88 on instance a and reset it during the 4th SHIFT cycle.
  task automatic abort_test();
    @(negedge clk);
    bcd_a = 8'h88; start_a = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start_a = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_bin_out", int'(bin_a), 0);
        chk("abort_err", int'(err_a), 0);
        chk("abort_state", int'(st_a), int'(ST_IDLE));
        rst = 1'b0;
      end
    end
    idle(12);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start_a = 1'b0; bcd_a = '0;
    start_b = 1'b0; bcd_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_busy", int'(busy_a), 0);
    chk("rst_a_done", int'(done_a), 0);
    chk("rst_a_bin", int'(bin_a), 0);
    chk("rst_a_err", int'(err_a), 0);
    chk("rst_a_state", int'(st_a), int'(ST_IDLE));
    chk("rst_b_bin", int'(bin_b), 0);
    chk("rst_b_state", int'(st_b), int'(ST_IDLE));
    rst = 1'b0;
    idle(2);

    // legal conversions, 8-cycle latency
    convert(1'b0, 12'h015, 15, 1'b0, 8, 0, 12'h000);
    convert(1'b0, 12'h099, 99, 1'b0, 8, 0, 12'h000);
    convert(1'b0, 12'h000,  0, 1'b0, 8, 0, 12'h000);
    convert(1'b0, 12'h059, 59, 1'b0, 8, 0, 12'h000);

    // illegal nibble: 1-cycle error path, then a legal one clears err
    convert(1'b0, 12'h01A,  0, 1'b1, 1, 0, 12'h000);
    chk("err_held", int'(err_a), 1);
    convert(1'b0, 12'h023, 23, 1'b0, 8, 0, 12'h000);

    // start during SHIFT is ignored
    convert(1'b0, 12'h042, 42, 1'b0, 8, 3, 12'h007);
    idle(12);
    chk("bin_held_after_ignored_start", int'(bin_a), 42);
    chk("idle_after_ignored_start", int'(busy_a), 0);

    // reset mid-conversion aborts, then a normal conversion
    abort_test();
    convert(1'b0, 12'h012, 12, 1'b0, 8, 0, 12'h000);

    // wide instance
    convert(1'b1, 12'h999, 999, 1'b0, 11, 0, 12'h000);
    convert(1'b1, 12'h100, 100, 1'b0, 11, 0, 12'h000);

    idle(4);
    chk("a_queue_empty", exp_a_q.size(), 0);
    chk("b_queue_empty", exp_b_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Iterative BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any BCD nibble >= 8. One bit is resolved per clock.
- It is the inverse of the clock's binary-to-BCD display path.
- Converts user-entered BCD time fields (hours/minutes from the set-time keypad/buttons) back into binary counter values for the alarm-compare and timekeeping logic.
- Uses a start/busy/done handshake so it can be shared between the alarm and clock setting paths.

Parameters:
- DIGITS, 2, number of BCD digits in the input word.
- BIN_W, 7, binary output width. Must satisfy 2^BIN_W > 10^DIGITS - 1; the default covers 0..99.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0]
- busy  output  1  high while a conversion is in flight (LOAD through DONE)
- done  output  1  one-cycle pulse when bin_out/err become valid
- bin_out  output  BIN_W  converted value; held until the next accepted start
- err  output  1  set if any input nibble > 9; held with bin_out

Behaviour:
- Reset: rst is synchronous and active-high, clock is clk. On reset, state=IDLE, busy=0, done=0, bin_out=0, err=0, and the internal shift registers are cleared. A reset asserted mid-conversion aborts it; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, latch bcd_in into bcd_r and clear bin_r and the iteration counter.
  - If any nibble > 9, go to DONE with err_next=1 and bin_next=0.
  - Otherwise go to SHIFT.
  - busy goes high in the cycle after start is accepted.
- SHIFT, one iteration per cycle:
  - Shift {bcd_r, bin_r} right by 1: bcd_r LSB enters bin_r MSB, and bcd_r MSB fills with 0.
  - Then, on the shifted value, replace every nibble of bcd_r that is >= 8 with nibble - 3. All nibbles are corrected in parallel in the same cycle.
  - The counter increments each cycle. After BIN_W iterations, go to DONE.
- DONE:
  - bin_out <= bin_r (or 0 on error), err updated, done=1 for exactly this one cycle, busy=1.
  - Next state is IDLE.
- Latency: start accepted at edge t, then done=1 during cycle t+BIN_W+1. That is 8 cycles for the default. The error path gives done at t+1.
- Arithmetic: bcd_r nibbles never exceed 12 before correction, so 4 bits suffice. bin_r is exactly BIN_W bits; no overflow for legal inputs when the parameter constraint holds.
- Start while busy (SHIFT or DONE) is ignored and is not queued.
- start held continuously: a new conversion is accepted in the IDLE cycle after DONE, so throughput is one conversion per BIN_W+2 cycles.
- bcd_in is only sampled at acceptance; changes during SHIFT have no effect.
- bin_out and err change only in DONE and are otherwise stable.

Decomposition:
- Shared header/package: state encodings (ST_IDLE, ST_SHIFT, ST_DONE) and a BCD_DIGIT_MAX=9 constant, reused by the display-side converter.
- Sub-module bcd_nibble_adj: 4-bit combinational block computing out = (in >= 8) ? in - 3 : in. Instantiated DIGITS times via generate.
- Counter width is $clog2(BIN_W+1).

Test Plan:
- Reset, then start with bcd_in=8'h15 -> done exactly 8 cycles after acceptance; bin_out=7'd15, err=0; busy high for 8 cycles.
- bcd_in=8'h99 -> bin_out=7'h63 (99). Then bcd_in=8'h00 -> bin_out=0. Then bcd_in=8'h59 -> bin_out=59.
- bcd_in=8'h1A -> done one cycle after acceptance with err=1, bin_out=0. A following legal 8'h23 clears err and gives bin_out=23.
- Accept 8'h42, pulse start with 8'h07 during SHIFT -> second request ignored; bin_out=42 and only one done pulse.
- Assert rst during the 4th SHIFT cycle of 8'h88 -> no done, outputs 0, state IDLE. Next start 8'h12 converts normally to 12.
- DIGITS=3, BIN_W=10, bcd_in=12'h999 -> bin_out=10'd999 after 11 cycles. Then 12'h100 -> bin_out=100.
